// File: rtl/trng_word_assembler.sv
// rtl/trng_word_assembler.sv - von Neumann debiased TRNG word packer with repetition-count health test
module trng_word_assembler #(
    parameter int TRNG_WIDTH = 4,
    parameter int RCT_CUTOFF = 32,
    parameter int DEBIAS     = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  raw_bit,
    input  logic                  raw_valid,
    input  logic                  trng_req,
    output logic [TRNG_WIDTH-1:0] trng_word,
    output logic                  trng_valid,
    output logic                  health_fail
);
    localparam int CW = $clog2(TRNG_WIDTH + 1);
    localparam int RW = $clog2(RCT_CUTOFF + 1);

    typedef enum logic {S_WAIT, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic                    pair_flag, pair_first;
    logic                    acc_valid, acc_bit;
    logic [TRNG_WIDTH-1:0]   sreg, buffer;
    logic [CW-1:0]           count;
    logic                    buf_full;
    logic [RW-1:0]           rct_cnt;
    logic                    prev_bit;
    logic                    word_complete, deliver;

    always_comb begin
        acc_valid = 1'b0;
        acc_bit   = 1'b0;
        if (DEBIAS != 0) begin
            // Only an unequal pair yields a bit; its value is the first sample
            if (raw_valid && pair_flag && (pair_first != raw_bit)) begin
                acc_valid = 1'b1;
                acc_bit   = pair_first;
            end
        end else begin
            acc_valid = raw_valid;
            acc_bit   = raw_bit;
        end
    end

    assign word_complete = (count == CW'(TRNG_WIDTH));

    always_comb begin
        state_d = state_q;
        deliver = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (trng_req && buf_full && !health_fail) begin
                    deliver = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!trng_req) state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= S_WAIT;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pair_flag  <= 1'b0;
            pair_first <= 1'b0;
            sreg       <= '0;
            count      <= '0;
            buffer     <= '0;
            buf_full   <= 1'b0;
            trng_word  <= '0;
            trng_valid <= 1'b0;
        end else begin
            if (raw_valid) begin
                pair_flag  <= !pair_flag;
                pair_first <= raw_bit;
            end
            // A delivery frees the buffer in the same cycle, so a finished word may move in
            if (word_complete && (!buf_full || deliver)) begin
                buffer   <= sreg;
                buf_full <= 1'b1;
                if (acc_valid) begin
                    sreg  <= {{(TRNG_WIDTH-1){1'b0}}, acc_bit};
                    count <= CW'(1);
                end else begin
                    count <= '0;
                end
            end else begin
                if (deliver) buf_full <= 1'b0;
                if (acc_valid && !word_complete) begin
                    sreg  <= {sreg[TRNG_WIDTH-2:0], acc_bit};
                    count <= count + CW'(1);
                end
            end
            trng_valid <= deliver;
            if (deliver) trng_word <= buffer;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rct_cnt     <= RW'(1);
            prev_bit    <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            if (raw_valid) begin
                prev_bit <= raw_bit;
                if (raw_bit == prev_bit) begin
                    if (rct_cnt != RW'(RCT_CUTOFF)) rct_cnt <= rct_cnt + RW'(1);
                end else begin
                    rct_cnt <= RW'(1);
                end
            end
            if (rct_cnt == RW'(RCT_CUTOFF)) health_fail <= 1'b1;
        end
    end
endmodule
